// File: rtl/rename_unit.sv
// Register rename stage: RAT lookup with intra-group forwarding, circular free list, retire frees; optional RENAME_STATS_EN counters.
// Latency 1 (registered outputs); o_ready drops while output is held or fewer than WIDTH PRegs are free.
module rename_unit #(
   parameter int WIDTH = 2,
   parameter int NUM_AREGS = 32,
   parameter int NUM_PREGS = 128,
   parameter int FREE_W = 2,
   parameter int PAYLOAD_W = 64,
   localparam int AW = $clog2(NUM_AREGS),
   localparam int PW = $clog2(NUM_PREGS)
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_valid,
   output logic                       o_ready,
   input  logic [WIDTH-1:0]           i_slot_valid,
   input  logic [WIDTH*AW-1:0]        i_src0_areg,
   input  logic [WIDTH*AW-1:0]        i_src1_areg,
   input  logic [WIDTH*AW-1:0]        i_dst_areg,
   input  logic [WIDTH*PAYLOAD_W-1:0] i_payload,
   input  logic [FREE_W-1:0]          i_free_valid,
   input  logic [FREE_W*PW-1:0]       i_free_preg,
   output logic                       o_valid,
   input  logic                       i_out_ready,
   output logic [WIDTH-1:0]           o_slot_valid,
   output logic [WIDTH*PW-1:0]        o_src0_preg,
   output logic [WIDTH*PW-1:0]        o_src1_preg,
   output logic [WIDTH*PW-1:0]        o_dst_preg,
   output logic [WIDTH*PW-1:0]        o_old_dst_preg,
   output logic [WIDTH*PAYLOAD_W-1:0] o_payload,
   output logic [PW:0]                o_free_count
`ifdef RENAME_STATS_EN
   ,
   output logic [31:0]                o_stall_cycles,
   output logic [31:0]                o_renamed_insts
`endif
);
   localparam int FL_DEPTH = NUM_PREGS - NUM_AREGS;
   localparam int FW = $clog2(FL_DEPTH);
   localparam logic [FW:0] FL_DEPTH_I = (FW+1)'(FL_DEPTH);
   localparam logic [PW:0] FL_DEPTH_C = (PW+1)'(FL_DEPTH);
   localparam logic [PW:0] WIDTH_C = (PW+1)'(WIDTH);

   logic [PW-1:0] rat [NUM_AREGS];
   logic [PW-1:0] fl [FL_DEPTH];
   logic [FW-1:0] head, tail, head_next, tail_next;
   logic [PW:0]   count, count_next;
   logic          accept;

   function automatic logic [FW-1:0] fl_wrap(input logic [FW:0] idx);
      if (idx >= FL_DEPTH_I) return FW'(idx - FL_DEPTH_I);
      return idx[FW-1:0];
   endfunction

   assign o_ready = (!o_valid || i_out_ready) && (count >= WIDTH_C);
   assign accept = i_valid && o_ready;
   assign o_free_count = count;

   logic [WIDTH-1:0] alloc;
   logic [PW-1:0]    new_dst [WIDTH];
   logic [PW-1:0]    src0_m [WIDTH];
   logic [PW-1:0]    src1_m [WIDTH];
   logic [PW-1:0]    old_m [WIDTH];
   logic [FW:0]      n_pop;

   // Lower slots that allocate shadow the RAT for every later slot in the group.
   always_comb begin
      n_pop = '0;
      alloc = '0;
      for (int k = 0; k < WIDTH; k++) begin
         new_dst[k] = '0;
         src0_m[k] = '0;
         src1_m[k] = '0;
         old_m[k] = '0;
      end
      for (int k = 0; k < WIDTH; k++) begin
         src0_m[k] = rat[i_src0_areg[k*AW +: AW]];
         src1_m[k] = rat[i_src1_areg[k*AW +: AW]];
         old_m[k] = rat[i_dst_areg[k*AW +: AW]];
         for (int j = 0; j < k; j++) begin
            if (alloc[j] && i_dst_areg[j*AW +: AW] == i_src0_areg[k*AW +: AW]) src0_m[k] = new_dst[j];
            if (alloc[j] && i_dst_areg[j*AW +: AW] == i_src1_areg[k*AW +: AW]) src1_m[k] = new_dst[j];
            if (alloc[j] && i_dst_areg[j*AW +: AW] == i_dst_areg[k*AW +: AW]) old_m[k] = new_dst[j];
         end
         if (i_src0_areg[k*AW +: AW] == '0) src0_m[k] = '0;
         if (i_src1_areg[k*AW +: AW] == '0) src1_m[k] = '0;
         alloc[k] = i_slot_valid[k] && (i_dst_areg[k*AW +: AW] != '0);
         if (alloc[k]) new_dst[k] = fl[fl_wrap({1'b0, head} + n_pop)];
         else old_m[k] = '0;
         n_pop = n_pop + (FW+1)'(alloc[k]);
      end
      head_next = fl_wrap({1'b0, head} + n_pop);
   end

   logic [FREE_W-1:0] push_en;
   logic [FW-1:0]     push_idx [FREE_W];
   logic [FW:0]       n_push;
   logic [PW:0]       occ;

   // Frees land behind this cycle's pops; anything beyond capacity is dropped.
   always_comb begin
      n_push = '0;
      push_en = '0;
      occ = count - (accept ? (PW+1)'(n_pop) : '0);
      for (int f = 0; f < FREE_W; f++) begin
         push_idx[f] = '0;
         if (i_free_valid[f] && i_free_preg[f*PW +: PW] != '0 && occ < FL_DEPTH_C) begin
            push_en[f] = 1'b1;
            push_idx[f] = fl_wrap({1'b0, tail} + n_push);
            n_push = n_push + (FW+1)'(1);
            occ = occ + (PW+1)'(1);
         end
      end
      tail_next = fl_wrap({1'b0, tail} + n_push);
      count_next = occ;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < NUM_AREGS; i++) rat[i] <= PW'(i);
         for (int i = 0; i < FL_DEPTH; i++) fl[i] <= PW'(NUM_AREGS + i);
         head <= '0;
         tail <= '0;
         count <= FL_DEPTH_C;
         o_valid <= 1'b0;
         o_slot_valid <= '0;
         o_src0_preg <= '0;
         o_src1_preg <= '0;
         o_dst_preg <= '0;
         o_old_dst_preg <= '0;
         o_payload <= '0;
      end else begin
         if (accept) begin
            for (int k = 0; k < WIDTH; k++) begin
               if (alloc[k]) rat[i_dst_areg[k*AW +: AW]] <= new_dst[k];
               o_src0_preg[k*PW +: PW] <= src0_m[k];
               o_src1_preg[k*PW +: PW] <= src1_m[k];
               o_dst_preg[k*PW +: PW] <= new_dst[k];
               o_old_dst_preg[k*PW +: PW] <= old_m[k];
            end
            head <= head_next;
            o_valid <= 1'b1;
            o_slot_valid <= i_slot_valid;
            o_payload <= i_payload;
         end else if (i_out_ready) begin
            o_valid <= 1'b0;
         end
         for (int f = 0; f < FREE_W; f++)
            if (push_en[f]) fl[push_idx[f]] <= i_free_preg[f*PW +: PW];
         tail <= tail_next;
         count <= count_next;
      end
   end

`ifdef RENAME_STATS_EN
   logic [31:0] n_valid;
   assign n_valid = 32'($countones(i_slot_valid));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_stall_cycles <= '0;
         o_renamed_insts <= '0;
      end else begin
         if (i_valid && !o_ready && count < WIDTH_C && o_stall_cycles != '1)
            o_stall_cycles <= o_stall_cycles + 32'd1;
         if (accept)
            o_renamed_insts <= (o_renamed_insts > ~n_valid) ? '1 : o_renamed_insts + n_valid;
      end
   end
`endif
endmodule

// File: tb/tb_rename_unit.sv
// Directed bench for rename_unit at default parameters.
module tb_rename_unit;
   localparam int WIDTH = 2;
   localparam int AW = 5;
   localparam int PW = 7;
   localparam int PAYLOAD_W = 64;
   localparam int FREE_W = 2;

   logic i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   logic                       i_rst;
   logic                       i_valid;
   logic                       o_ready;
   logic [WIDTH-1:0]           i_slot_valid;
   logic [WIDTH*AW-1:0]        i_src0_areg, i_src1_areg, i_dst_areg;
   logic [WIDTH*PAYLOAD_W-1:0] i_payload;
   logic [FREE_W-1:0]          i_free_valid;
   logic [FREE_W*PW-1:0]       i_free_preg;
   logic                       o_valid;
   logic                       i_out_ready;
   logic [WIDTH-1:0]           o_slot_valid;
   logic [WIDTH*PW-1:0]        o_src0_preg, o_src1_preg, o_dst_preg, o_old_dst_preg;
   logic [WIDTH*PAYLOAD_W-1:0] o_payload;
   logic [PW:0]                o_free_count;
`ifdef RENAME_STATS_EN
   logic [31:0]                o_stall_cycles, o_renamed_insts;
`endif

   rename_unit #(.WIDTH(WIDTH), .NUM_AREGS(32), .NUM_PREGS(128), .FREE_W(FREE_W), .PAYLOAD_W(PAYLOAD_W)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
      .i_slot_valid(i_slot_valid), .i_src0_areg(i_src0_areg), .i_src1_areg(i_src1_areg),
      .i_dst_areg(i_dst_areg), .i_payload(i_payload), .i_free_valid(i_free_valid),
      .i_free_preg(i_free_preg), .o_valid(o_valid), .i_out_ready(i_out_ready),
      .o_slot_valid(o_slot_valid), .o_src0_preg(o_src0_preg), .o_src1_preg(o_src1_preg),
      .o_dst_preg(o_dst_preg), .o_old_dst_preg(o_old_dst_preg), .o_payload(o_payload),
      .o_free_count(o_free_count)
`ifdef RENAME_STATS_EN
      , .o_stall_cycles(o_stall_cycles), .o_renamed_insts(o_renamed_insts)
`endif
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic set_slot(input int k, input logic v, input logic [AW-1:0] d,
                           input logic [AW-1:0] s0, input logic [AW-1:0] s1);
      i_slot_valid[k] = v;
      i_dst_areg[k*AW +: AW] = d;
      i_src0_areg[k*AW +: AW] = s0;
      i_src1_areg[k*AW +: AW] = s1;
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      i_valid = 1'b0;
      i_free_valid = '0;
      step();
      i_rst = 1'b0;
   endtask

   initial begin
      i_rst = 1'b1;
      i_valid = 1'b0;
      i_out_ready = 1'b1;
      i_slot_valid = '0;
      i_src0_areg = '0;
      i_src1_areg = '0;
      i_dst_areg = '0;
      i_payload = '0;
      i_free_valid = '0;
      i_free_preg = '0;
      step();
      step();
      chk("rst_valid", 32'(o_valid), 0);
      chk("rst_count", 32'(o_free_count), 96);
      chk("rst_dst", 32'(o_dst_preg), 0);
      chk("rst_ready", 32'(o_ready), 1);
      i_rst = 1'b0;

      // basic group with dependency slot1.src0 on slot0.dst
      set_slot(0, 1, 5, 1, 0);
      set_slot(1, 1, 6, 5, 0);
      i_valid = 1'b1;
      step();
      i_valid = 1'b0;
      chk("g1_valid", 32'(o_valid), 1);
      chk("g1_s0_src0", 32'(o_src0_preg[6:0]), 1);
      chk("g1_s0_src1", 32'(o_src1_preg[6:0]), 0);
      chk("g1_s0_dst", 32'(o_dst_preg[6:0]), 32);
      chk("g1_s0_old", 32'(o_old_dst_preg[6:0]), 5);
      chk("g1_s1_src0", 32'(o_src0_preg[13:7]), 32);
      chk("g1_s1_dst", 32'(o_dst_preg[13:7]), 33);
      chk("g1_s1_old", 32'(o_old_dst_preg[13:7]), 6);
      chk("g1_count", 32'(o_free_count), 94);

      // same destination twice in one group
      do_reset();
      set_slot(0, 1, 7, 0, 0);
      set_slot(1, 1, 7, 0, 7);
      i_valid = 1'b1;
      step();
      chk("g2_s0_dst", 32'(o_dst_preg[6:0]), 32);
      chk("g2_s0_old", 32'(o_old_dst_preg[6:0]), 7);
      chk("g2_s1_src1", 32'(o_src1_preg[13:7]), 32);
      chk("g2_s1_dst", 32'(o_dst_preg[13:7]), 33);
      chk("g2_s1_old", 32'(o_old_dst_preg[13:7]), 32);
      set_slot(0, 1, 0, 7, 0);
      set_slot(1, 0, 4, 3, 3);
      i_payload = {64'hCAFE_F00D_1234_5678, 64'h0};
      step();
      i_valid = 1'b0;
      chk("g2_read_x7", 32'(o_src0_preg[6:0]), 33);
      chk("g2_read_dst", 32'(o_dst_preg[6:0]), 0);
      chk("g2_inv_dst", 32'(o_dst_preg[13:7]), 0);
      chk("g2_slot_valid", 32'(o_slot_valid), 1);
      chk("g2_payload", o_payload[127:96], 32'hCAFE_F00D);
      chk("g2_count", 32'(o_free_count), 94);

      // x0 destination does not allocate
      do_reset();
      set_slot(0, 1, 0, 0, 0);
      set_slot(1, 1, 3, 0, 0);
      i_valid = 1'b1;
      step();
      i_valid = 1'b0;
      chk("g3_s0_dst", 32'(o_dst_preg[6:0]), 0);
      chk("g3_s0_old", 32'(o_old_dst_preg[6:0]), 0);
      chk("g3_s1_dst", 32'(o_dst_preg[13:7]), 32);
      chk("g3_count", 32'(o_free_count), 95);

      // free-list exhaustion and refill
      do_reset();
      set_slot(0, 1, 1, 0, 0);
      set_slot(1, 1, 2, 0, 0);
      i_valid = 1'b1;
      for (int i = 0; i < 48; i++) step();
      i_valid = 1'b0;
      chk("ex_last_dst0", 32'(o_dst_preg[6:0]), 126);
      chk("ex_last_dst1", 32'(o_dst_preg[13:7]), 127);
      chk("ex_count", 32'(o_free_count), 0);
      chk("ex_ready", 32'(o_ready), 0);
      i_free_valid = 2'b01;
      i_free_preg = {7'd0, 7'd5};
      step();
      chk("ex_free5_count", 32'(o_free_count), 1);
      chk("ex_free5_ready", 32'(o_ready), 0);
      i_free_preg = {7'd0, 7'd6};
      step();
      i_free_valid = '0;
      chk("ex_free6_count", 32'(o_free_count), 2);
      chk("ex_free6_ready", 32'(o_ready), 1);
      set_slot(0, 1, 8, 0, 0);
      set_slot(1, 1, 9, 0, 0);
      i_valid = 1'b1;
      step();
      i_valid = 1'b0;
      chk("ex_realloc0", 32'(o_dst_preg[6:0]), 5);
      chk("ex_realloc1", 32'(o_dst_preg[13:7]), 6);
      chk("ex_realloc_count", 32'(o_free_count), 0);
      i_free_valid = 2'b11;
      i_free_preg = {7'd41, 7'd0};
      step();
      i_free_valid = '0;
      chk("ex_preg0_ignored", 32'(o_free_count), 1);

      // output backpressure
      do_reset();
      i_out_ready = 1'b0;
      set_slot(0, 1, 5, 0, 0);
      set_slot(1, 1, 6, 0, 0);
      i_valid = 1'b1;
      step();
      chk("bp_valid", 32'(o_valid), 1);
      set_slot(0, 1, 8, 0, 0);
      set_slot(1, 1, 9, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_hold_valid", 32'(o_valid), 1);
         chk("bp_hold_dst", 32'(o_dst_preg[6:0]), 32);
         chk("bp_hold_ready", 32'(o_ready), 0);
         chk("bp_hold_count", 32'(o_free_count), 94);
      end
      i_out_ready = 1'b1;
      step();
      i_valid = 1'b0;
      chk("bp_next_dst0", 32'(o_dst_preg[6:0]), 34);
      chk("bp_next_dst1", 32'(o_dst_preg[13:7]), 35);
      chk("bp_next_count", 32'(o_free_count), 92);
      step();
      chk("bp_drain_valid", 32'(o_valid), 0);
      chk("bp_drain_count", 32'(o_free_count), 92);

      // reset while output held and frees pending
      i_out_ready = 1'b0;
      set_slot(0, 1, 3, 0, 0);
      set_slot(1, 0, 0, 0, 0);
      i_valid = 1'b1;
      step();
      chk("mr_valid_before", 32'(o_valid), 1);
      i_rst = 1'b1;
      i_valid = 1'b0;
      i_free_valid = 2'b11;
      i_free_preg = {7'd41, 7'd40};
      step();
      i_rst = 1'b0;
      i_free_valid = '0;
      chk("mr_valid", 32'(o_valid), 0);
      chk("mr_count", 32'(o_free_count), 96);
      i_valid = 1'b1;
      step();
      i_valid = 1'b0;
      chk("mr_first_dst", 32'(o_dst_preg[6:0]), 32);
      chk("mr_first_count", 32'(o_free_count), 95);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
